// File: rtl/seg7_pkg.sv
// Shared encodings and glyph table for the seven-segment scan controller.
// Glyphs are active-high, bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

    typedef enum logic [1:0] {
        MODE_SCAN       = 2'd0,
        MODE_MANUAL_SEL = 2'd1,
        MODE_BLANK      = 2'd2,
        MODE_LAMP_TEST  = 2'd3
    } mode_e;

    localparam logic [7:0] SEG_OFF    = 8'h00;
    localparam logic [7:0] SEG_ALL_ON = 8'hFF;

    // Concatenated so that GLYPHS[0] is the '0' glyph and GLYPHS[15] is 'F'.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bus between the CPU display register / board pins and the scan controller.
// The controller takes the slave side; the driver of data and mode takes master.
interface seg7_scan_ctrl_if
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    mode_e                   mode;
    logic [NUM_DIGITS-1:0]   ovr_sel;
    logic [NUM_DIGITS-1:0]   sel;
    logic [7:0]              seg;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;
    logic                    pending;

    modport master (
        output load, data_in, dp_in, blank_in, mode, ovr_sel,
        input  sel, seg, digit_idx, frame_tick, pending
    );

    modport slave (
        input  load, data_in, dp_in, blank_in, mode, ovr_sel,
        output sel, seg, digit_idx, frame_tick, pending
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex-to-segment decode, active-high; the caller applies polarity.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    assign o_seg = i_blank ? SEG_OFF : {i_dp, GLYPHS[i_nibble]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-aligned double buffering,
// anti-ghosting blank cycles and manual-select / blank / lamp-test modes.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input logic              clk,
    input logic              reset,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PCNT_W = $clog2(REFRESH_DIV);

    localparam logic [7:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] SEL_POL = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PCNT_W-1:0]       r_pcnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_act_data, r_pend_data;
    logic [NUM_DIGITS-1:0]   r_act_dp, r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_act_blank, r_pend_blank;
    logic                    r_pending;
    logic                    r_frame_tick;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic [7:0]              r_seg;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blank;
    logic [7:0]              w_dec_seg;
    logic [NUM_DIGITS-1:0]   w_scan_sel;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;
    logic [7:0]              w_seg_nxt;

    assign w_slot_end = (r_pcnt == PCNT_W'(REFRESH_DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));

    assign w_nibble = 4'(r_act_data >> {r_idx, 2'b00});
    assign w_dp     = 1'(r_act_dp >> r_idx);
    assign w_blank  = 1'(r_act_blank >> r_idx);

    seg7_decoder u_decoder (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .i_blank  (w_blank),
        .o_seg    (w_dec_seg)
    );

    // Select stays dark for the first BLANK_CYCLES of each slot to hide ghosting.
    assign w_scan_sel = (r_pcnt < PCNT_W'(BLANK_CYCLES)) ? '0
                                                          : (NUM_DIGITS'(1) << r_idx);

    always_comb begin
        w_sel_nxt = w_scan_sel ^ SEL_POL;
        w_seg_nxt = w_dec_seg ^ SEG_POL;
        unique case (bus.mode)
            MODE_MANUAL_SEL: w_sel_nxt = bus.ovr_sel;
            MODE_BLANK:      w_seg_nxt = SEG_OFF ^ SEG_POL;
            MODE_LAMP_TEST: begin
                w_sel_nxt = ~SEL_POL;
                w_seg_nxt = SEG_ALL_ON ^ SEG_POL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt       <= '0;
            r_idx        <= '0;
            r_act_data   <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_sel        <= SEL_POL;
            r_seg        <= SEG_OFF ^ SEG_POL;
        end else begin
            r_pcnt       <= w_slot_end ? '0 : r_pcnt + PCNT_W'(1);
            r_frame_tick <= w_wrap;
            if (w_slot_end)
                r_idx <= w_wrap ? '0 : r_idx + IDX_W'(1);

            // A load in the wrap cycle bypasses the pending buffer and commits directly.
            if (w_wrap) begin
                if (bus.load) begin
                    r_act_data  <= bus.data_in;
                    r_act_dp    <= bus.dp_in;
                    r_act_blank <= bus.blank_in;
                end else if (r_pending) begin
                    r_act_data  <= r_pend_data;
                    r_act_dp    <= r_pend_dp;
                    r_act_blank <= r_pend_blank;
                end
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end

            if (bus.load) begin
                r_pend_data  <= bus.data_in;
                r_pend_dp    <= bus.dp_in;
                r_pend_blank <= bus.blank_in;
            end

            r_sel <= w_sel_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign bus.sel        = r_sel;
    assign bus.seg        = r_seg;
    assign bus.digit_idx  = r_idx;
    assign bus.frame_tick = r_frame_tick;
    assign bus.pending    = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 4-cycle slots, 1 blank cycle).
module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (4),
        .BLANK_CYCLES   (1),
        .SEG_ACTIVE_LOW (1),
        .SEL_ACTIVE_LOW (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic [1:0] idx;
        logic       ft;
        logic       pend;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_tick = -1;
    bit   chk_d2 = 0;
    bit   chk_8 = 0;
    bit   saw_f = 0;

    // Reference state of the scanner
    logic [1:0]  m_pcnt, m_idx;
    logic [15:0] m_act_data, m_pend_data;
    logic [3:0]  m_act_dp, m_pend_dp, m_act_blank, m_pend_blank;
    logic        m_pending;

    function automatic logic [7:0] glyph_al(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t       e;
        logic       wrap;
        logic [3:0] nib;
        logic [7:0] dseg;
        logic [3:0] ssel;
        if (reset) begin
            e = '{sel: 4'b0000, seg: 8'hFF, idx: 2'd0, ft: 1'b0, pend: 1'b0};
            m_pcnt = 0; m_idx = 0; m_pending = 0;
            m_act_data = 0; m_act_dp = 0; m_act_blank = 0;
            m_pend_data = 0; m_pend_dp = 0; m_pend_blank = 0;
            last_tick = -1;
        end else begin
            nib  = m_act_data[4*m_idx +: 4];
            dseg = m_act_blank[m_idx] ? 8'hFF
                                      : (glyph_al(nib) & (m_act_dp[m_idx] ? 8'h7F : 8'hFF));
            ssel = (m_pcnt == 2'd0) ? 4'b0000 : (4'b0001 << m_idx);
            e.sel = ssel;
            e.seg = dseg;
            case (bus.mode)
                MODE_MANUAL_SEL: e.sel = bus.ovr_sel;
                MODE_BLANK:      e.seg = 8'hFF;
                MODE_LAMP_TEST:  begin e.sel = 4'b1111; e.seg = 8'h00; end
                default: ;
            endcase
            wrap = (m_pcnt == 2'd3) && (m_idx == 2'd3);
            if (wrap) begin
                if (bus.load) begin
                    m_act_data = bus.data_in; m_act_dp = bus.dp_in; m_act_blank = bus.blank_in;
                end else if (m_pending) begin
                    m_act_data = m_pend_data; m_act_dp = m_pend_dp; m_act_blank = m_pend_blank;
                end
                m_pending = 0;
            end else if (bus.load) begin
                m_pending = 1;
            end
            if (bus.load) begin
                m_pend_data = bus.data_in; m_pend_dp = bus.dp_in; m_pend_blank = bus.blank_in;
            end
            if (m_pcnt == 2'd3) m_idx = m_idx + 2'd1;
            m_pcnt = m_pcnt + 2'd1;
            e.idx  = m_idx;
            e.ft   = wrap;
            e.pend = m_pending;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        bus.load = 1'b0;
        e = sb.pop_front();
        chk("sel", bus.sel, e.sel);
        chk("seg", bus.seg, e.seg);
        chk("digit_idx", bus.digit_idx, e.idx);
        chk("frame_tick", bus.frame_tick, e.ft);
        chk("pending", bus.pending, e.pend);
        if (bus.frame_tick === 1'b1) begin
            if (last_tick >= 0) chk("frame_period", cyc - last_tick, 16);
            last_tick = cyc;
        end
        if (chk_d2 && bus.sel === 4'b0100) chk("digit2_dp", bus.seg, 8'h24);
        if (chk_8 && bus.sel !== 4'b0000) chk("all_eights", bus.seg, 8'h80);
        if (bus.seg === 8'h8E) saw_f = 1;
    endtask

    task automatic wait_for(input logic [1:0] idx, input logic [1:0] pc);
        int n = 0;
        while (!(m_idx == idx && m_pcnt == pc) && n < 40) begin
            step();
            n++;
        end
        if (!(m_idx == idx && m_pcnt == pc)) chk("wait_timeout", 32'(n), 32'(0));
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;
        bus.mode     = MODE_SCAN;
        bus.ovr_sel  = '0;
        reset        = 1'b1;

        repeat (3) step();
        chk("rst_seg", bus.seg, 8'hFF);
        chk("rst_sel", bus.sel, 4'b0000);
        chk("rst_pending", bus.pending, 0);
        chk("rst_frame_tick", bus.frame_tick, 0);
        reset = 1'b0;

        // Scan two frames of 3210 with dp on digit 2
        bus.data_in = 16'h3210;
        bus.dp_in   = 4'b0100;
        bus.load    = 1'b1;
        step();
        chk("pending_after_load", bus.pending, 1);
        repeat (20) step();
        chk_d2 = 1;
        repeat (20) step();
        chk_d2 = 0;

        // Double buffer: FFFF is overwritten by 8888 before the wrap
        wait_for(2'd1, 2'd1);
        saw_f = 0;
        bus.data_in = 16'hFFFF;
        bus.dp_in   = 4'b0000;
        bus.load    = 1'b1;
        step();
        repeat (2) step();
        chk("old_digits_kept", bus.seg, 8'hF9);
        bus.data_in = 16'h8888;
        bus.load    = 1'b1;
        step();
        wait_for(2'd3, 2'd3);
        step();
        chk_8 = 1;
        repeat (16) step();
        chk_8 = 0;
        chk("ffff_never_shown", saw_f, 0);

        // Load coincident with the wrap commits immediately
        wait_for(2'd3, 2'd3);
        bus.data_in = 16'h4567;
        bus.load    = 1'b1;
        step();
        chk("coinc_pending", bus.pending, 0);
        chk("coinc_tick", bus.frame_tick, 1);
        step();
        chk("coinc_commit", bus.seg, 8'hF8);
        repeat (14) step();

        // Modes
        bus.ovr_sel = 4'b1010;
        bus.mode    = MODE_MANUAL_SEL;
        step();
        chk("manual_sel", bus.sel, 4'b1010);
        repeat (5) step();
        bus.mode = MODE_BLANK;
        step();
        chk("blank_seg", bus.seg, 8'hFF);
        repeat (6) step();
        bus.mode = MODE_LAMP_TEST;
        step();
        chk("lamp_sel", bus.sel, 4'b1111);
        chk("lamp_seg", bus.seg, 8'h00);
        repeat (3) step();
        bus.mode = MODE_SCAN;

        // Per-digit blank mask
        bus.blank_in = 4'b0001;
        bus.load     = 1'b1;
        step();
        wait_for(2'd3, 2'd3);
        repeat (3) step();
        chk("blank_mask_sel", bus.sel, 4'b0001);
        chk("blank_mask_seg", bus.seg, 8'hFF);
        repeat (8) step();

        // Reset with data pending discards it
        bus.blank_in = 4'b0000;
        bus.data_in  = 16'hABCD;
        bus.load     = 1'b1;
        step();
        chk("pending_before_rst", bus.pending, 1);
        reset = 1'b1;
        step();
        chk("midrst_pending", bus.pending, 0);
        chk("midrst_seg", bus.seg, 8'hFF);
        chk("midrst_sel", bus.sel, 4'b0000);
        chk("midrst_idx", bus.digit_idx, 0);
        reset = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
